// File: rtl/countdown_timer.sv
// countdown_timer: four-digit BCD countdown timer, display format SS.hh (00.01 .. 99.99 s).
//
// The operator enters a preset digit by digit and starts the count. While running, the count
// can be paused and resumed, or aborted from pause. alarm_o is raised when the count reaches
// 00.00. Any button press while expired reloads the preset and returns to idle.
//
// Parameters:
//   TICK_DIV   clk100_i cycles per 1/100 s tick (>= 2)
// Ports:
//   clk100_i   system clock, 100 MHz
//   rstn_i     asynchronous active-low reset
//   start_i    start/pause pulse (one cycle, highest priority)
//   set_i      edit-mode / next-digit pulse (one cycle)
//   change_i   increment-selected-digit pulse (one cycle, lowest priority)
//   hex3_o..hex0_o  7-segment digits {g,f,e,d,c,b,a}, active-low: tens-of-s, s, tenths, hundredths
//   running_o  registered: state is RUN
//   alarm_o    registered: state is EXPIRED
// Build option:
//   COUNTDOWN_BLINK_EN  when defined, the selected digit blinks at 2 Hz in edit mode.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic       clk100_i,
  input  logic       rstn_i,
  input  logic       start_i,
  input  logic       set_i,
  input  logic       change_i,
  output logic [6:0] hex3_o,
  output logic [6:0] hex2_o,
  output logic [6:0] hex1_o,
  output logic [6:0] hex0_o,
  output logic       running_o,
  output logic       alarm_o
);

  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StEdit, StRun, StPause, StExpired} state_e;

  state_e              state_q;
  logic [3:0][3:0]     d_q;      // current value, [3] = tens of seconds
  logic [3:0][3:0]     p_q;      // preset
  logic [3:0][3:0]     d_dec;
  logic [1:0]          sel_q;
  logic [PreW-1:0]     presc_q;
  logic                running_q;
  logic                alarm_q;
  logic                tick;
  logic [3:0]          blank;

  function automatic logic [3:0] bcd_inc(input logic [3:0] v);
    return (v == 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

  // Subtract one hundredth; a zero digit borrows from the next one up and becomes 9.
  function automatic logic [3:0][3:0] bcd_dec(input logic [3:0][3:0] v);
    logic [3:0][3:0] r;
    logic            borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i] == 4'd0) begin
          r[i]   = 4'd9;
          borrow = 1'b1;
        end else begin
          r[i]   = v[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] dg, input logic blk);
    logic [6:0] s;
    case (dg)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return blk ? 7'b1111111 : s;
  endfunction

  assign tick = (presc_q == PreMax);

  always_comb begin
    d_dec = bcd_dec(d_q);
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      d_q       <= '0;
      p_q       <= '0;
      sel_q     <= 2'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      // Prescaler counts in every state except PAUSE; outside RUN it only feeds the blink.
      if (state_q != StPause) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
      end

      // Only the highest-priority pulse present is considered; the others are dropped.
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (d_q != '0) begin
              state_q   <= StRun;
              running_q <= 1'b1;
              presc_q   <= '0;
            end
          end else if (set_i) begin
            state_q <= StEdit;
            sel_q   <= 2'd3;
          end
        end
        StEdit: begin
          if (!start_i) begin
            if (set_i) begin
              if (sel_q != 2'd0) begin
                sel_q <= sel_q - 2'd1;
              end else begin
                state_q <= StIdle;
              end
            end else if (change_i) begin
              d_q[sel_q] <= bcd_inc(d_q[sel_q]);
              p_q[sel_q] <= bcd_inc(p_q[sel_q]);
            end
          end
        end
        StRun: begin
          if (start_i) begin
            // A coincident tick is discarded.
            state_q   <= StPause;
            running_q <= 1'b0;
          end else if (tick) begin
            d_q <= d_dec;
            if (d_dec == '0) begin
              state_q   <= StExpired;
              running_q <= 1'b0;
              alarm_q   <= 1'b1;
            end
          end
        end
        StPause: begin
          if (start_i) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end else if (set_i) begin
            state_q <= StIdle;
            d_q     <= p_q;
          end
        end
        StExpired: begin
          if (start_i || set_i || change_i) begin
            state_q <= StIdle;
            alarm_q <= 1'b0;
            d_q     <= p_q;
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
          alarm_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  logic [4:0] blink_cnt_q;
  logic       blink_q;

  // Phase toggles every 25 prescaler wraps, i.e. every 25 * TICK_DIV cycles.
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      blink_cnt_q <= 5'd0;
      blink_q     <= 1'b0;
    end else if (tick && state_q != StPause) begin
      if (blink_cnt_q == 5'd24) begin
        blink_cnt_q <= 5'd0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 5'd1;
      end
    end
  end

  assign blank = (state_q == StEdit && blink_q) ? (4'b0001 << sel_q) : 4'b0000;
`else
  assign blank = 4'b0000;
`endif

  assign hex3_o    = seg7(d_q[3], blank[3]);
  assign hex2_o    = seg7(d_q[2], blank[2]);
  assign hex1_o    = seg7(d_q[1], blank[1]);
  assign hex0_o    = seg7(d_q[0], blank[0]);
  assign running_o = running_q;
  assign alarm_o   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: the driver applies directed and random button pulses, steps a
// behavioural model (value held as an integer count of hundredths) and queues the expected
// outputs; a monitor pops one expectation per clock edge and compares it with the DUT.
module tb_countdown_timer;

  localparam int unsigned TD = 4;
  localparam int MIdle = 0, MEdit = 1, MRun = 2, MPause = 3, MExp = 4;

  logic       clk100_i = 1'b0;
  logic       rstn_i   = 1'b0;
  logic       start_i  = 1'b0;
  logic       set_i    = 1'b0;
  logic       change_i = 1'b0;
  logic [6:0] hex3_o, hex2_o, hex1_o, hex0_o;
  logic       running_o, alarm_o;

  countdown_timer #(.TICK_DIV(TD)) dut (
    .clk100_i (clk100_i),
    .rstn_i   (rstn_i),
    .start_i  (start_i),
    .set_i    (set_i),
    .change_i (change_i),
    .hex3_o   (hex3_o),
    .hex2_o   (hex2_o),
    .hex1_o   (hex1_o),
    .hex0_o   (hex0_o),
    .running_o(running_o),
    .alarm_o  (alarm_o)
  );

  always #5 clk100_i = ~clk100_i;

  // Reference model state
  int m_st, m_val, m_pre, m_sel, m_ph;
  int total = 0;
  int bad   = 0;
  logic [29:0] exp_q[$];
  logic [29:0] mon_exp, mon_act;

  function automatic int pow10(int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic int digit(int v, int i);
    return (v / pow10(i)) % 10;
  endfunction

  function automatic logic [6:0] seg(int dg);
    case (dg)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [29:0] expect_out();
    logic r, a;
    r = (m_st == MRun);
    a = (m_st == MExp);
    return {seg(digit(m_val, 3)), seg(digit(m_val, 2)), seg(digit(m_val, 1)),
            seg(digit(m_val, 0)), r, a};
  endfunction

  task automatic model_reset();
    m_st = MIdle; m_val = 0; m_pre = 0; m_sel = 0; m_ph = 0;
  endtask

  task automatic model_step(bit s, bit t, bit c);
    bit tick;
    int dg;
    case (m_st)
      MIdle: begin
        if (s) begin
          if (m_val != 0) begin m_st = MRun; m_ph = 0; end
        end else if (t) begin
          m_st = MEdit; m_sel = 3;
        end
      end
      MEdit: begin
        if (!s) begin
          if (t) begin
            if (m_sel > 0) m_sel = m_sel - 1;
            else m_st = MIdle;
          end else if (c) begin
            dg    = digit(m_val, m_sel);
            m_val = m_val + ((dg + 1) % 10 - dg) * pow10(m_sel);
            dg    = digit(m_pre, m_sel);
            m_pre = m_pre + ((dg + 1) % 10 - dg) * pow10(m_sel);
          end
        end
      end
      MRun: begin
        tick = (m_ph == int'(TD) - 1);
        m_ph = (m_ph + 1) % int'(TD);
        if (s) m_st = MPause;
        else if (tick) begin
          m_val = m_val - 1;
          if (m_val == 0) m_st = MExp;
        end
      end
      MPause: begin
        if (s) m_st = MRun;
        else if (t) begin m_st = MIdle; m_val = m_pre; end
      end
      default: begin
        if (s || t || c) begin m_st = MIdle; m_val = m_pre; end
      end
    endcase
  endtask

  task automatic cycle(bit s, bit t, bit c);
    @(negedge clk100_i);
    rstn_i   = 1'b1;
    start_i  = s;
    set_i    = t;
    change_i = c;
    model_step(s, t, c);
    exp_q.push_back(expect_out());
  endtask

  task automatic run(int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(string nm, logic [27:0] act, logic [27:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk100_i);
    rstn_i   = 1'b0;
    start_i  = 1'b0;
    set_i    = 1'b0;
    change_i = 1'b0;
    #1;
    check("rst_hex", {hex3_o, hex2_o, hex1_o, hex0_o}, {4{7'b1000000}});
    check("rst_alarm", 28'(alarm_o), 28'd0);
    model_reset();
    exp_q.push_back(expect_out());
  endtask

  // From IDLE: walk through all four digits, pressing change until each matches v.
  task automatic enter_preset(int v);
    int n;
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      n = (digit(v, i) - digit(m_val, i) + 10) % 10;
      repeat (n) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk100_i);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {hex3_o, hex2_o, hex1_o, hex0_o, running_o, alarm_o};
        total++;
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL out_cmp t=%0t got hex=%b run=%b alm=%b want hex=%b run=%b alm=%b",
                   $time, mon_act[29:2], mon_act[1], mon_act[0],
                   mon_exp[29:2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk100_i);
    do_reset();
    run(2);
    // Start with 00.00 stays idle
    cycle(1'b1, 1'b0, 1'b0);
    run(2);
    // Preset entry sequence -> 21.00
    cycle(1'b0, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    repeat (11) cycle(1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    run(2);
    // Countdown 00.03 to expiry, then change reloads
    enter_preset(3);
    cycle(1'b1, 1'b0, 1'b0);
    run(14);
    cycle(1'b0, 1'b0, 1'b1);
    run(3);
    // Borrow chain 10.00 -> 09.99
    enter_preset(1000);
    cycle(1'b1, 1'b0, 1'b0);
    run(5);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    run(2);
    // Pause / resume / start on tick / abort
    enter_preset(50);
    cycle(1'b1, 1'b0, 1'b0);
    run(9);
    cycle(1'b1, 1'b0, 1'b0);
    run(100);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < int'(TD) && m_ph != int'(TD) - 1; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    run(10);
    cycle(1'b0, 1'b1, 1'b0);
    run(2);
    // start+set together from IDLE: start wins
    enter_preset(500);
    cycle(1'b1, 1'b1, 1'b0);
    run(6);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    // Reset mid-run at 12.34 and while expired
    enter_preset(1234);
    cycle(1'b1, 1'b0, 1'b0);
    run(6);
    do_reset();
    run(3);
    enter_preset(1);
    cycle(1'b1, 1'b0, 1'b0);
    run(6);
    do_reset();
    run(2);
    // Random episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      run(1);
      enter_preset(int'($urandom_range(1, 60)));
      cycle(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 300; k++) begin
        cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 9) == 0));
      end
    end
    run(3);
    repeat (3) @(posedge clk100_i);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
